// File: rtl/bus_cycle_sequencer.sv
// Purpose : 8085-style machine-cycle sequencer: T1/T2/TWAIT/T3/T4 bus timing, hold and halt handling.
// Latency : all outputs registered; a cycle takes 3 T-states plus waits (4 plus waits for opcode fetch), then a done pulse in IDLE.
// Backpres: 'ready' low stretches T2 into TWAIT up to WAIT_LIMIT waits, then forces bus-error completion; start outside IDLE is dropped.
//
// Ports:
//   phi1, resetn_in          clock, synchronous active-low reset
//   start, cycle_type, addr, wdata   cycle request (captured when accepted in IDLE)
//   ad_in, ready, hold, wake bus read data, wait control, bus request, halt exit
//   haddress, ad_out, ad_oe  A15..A8 and multiplexed AD7..AD0 drive
//   ALE, S0, S1, IOMn, RDn, WRn      bus strobes and status
//   rdata, instr_load        read data, instruction-register load pulse
//   busy, done, bus_err, hlda, wait_cnt  status flags and wait-state count
module bus_cycle_sequencer #(
    parameter logic [7:0] WAIT_LIMIT = 8'd16
) (
    input  logic        phi1,
    input  logic        resetn_in,
    input  logic        start,
    input  logic [2:0]  cycle_type,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic [7:0]  ad_in,
    input  logic        ready,
    input  logic        hold,
    input  logic        wake,
    output logic [7:0]  haddress,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic        ALE,
    output logic        S0,
    output logic        S1,
    output logic        IOMn,
    output logic        RDn,
    output logic        WRn,
    output logic [7:0]  rdata,
    output logic        instr_load,
    output logic        busy,
    output logic        done,
    output logic        bus_err,
    output logic        hlda,
    output logic [7:0]  wait_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TWAIT,
        S_T3,
        S_T4,
        S_THOLD,
        S_THALT
    } state_t;

    localparam logic [2:0] CT_FETCH  = 3'd0;
    localparam logic [2:0] CT_MEM_RD = 3'd1;
    localparam logic [2:0] CT_MEM_WR = 3'd2;
    localparam logic [2:0] CT_IO_RD  = 3'd3;
    localparam logic [2:0] CT_IO_WR  = 3'd4;
    localparam logic [2:0] CT_INTA   = 3'd5;
    localparam logic [2:0] CT_HALT   = 3'd6;
    localparam logic [2:0] CT_RSVD   = 3'd7;

    function automatic logic is_write(input logic [2:0] t);
        return (t == CT_MEM_WR) || (t == CT_IO_WR);
    endfunction

    function automatic logic is_read(input logic [2:0] t);
        return (t == CT_FETCH) || (t == CT_MEM_RD) || (t == CT_IO_RD) || (t == CT_INTA);
    endfunction

    // {S1, S0, IOMn} for each cycle type
    function automatic logic [2:0] status_bits(input logic [2:0] t);
        logic [2:0] s;
        case (t)
            CT_FETCH:  s = 3'b110;
            CT_MEM_RD: s = 3'b100;
            CT_MEM_WR: s = 3'b010;
            CT_IO_RD:  s = 3'b101;
            CT_IO_WR:  s = 3'b011;
            CT_INTA:   s = 3'b111;
            default:   s = 3'b000;
        endcase
        return s;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_pend_q, err_pend_d;   // timeout seen; published on bus_err at completion

    logic [7:0]  wait_cnt_d, rdata_d, haddress_d, ad_out_d;
    logic        done_d, bus_err_d, ad_oe_d, ale_d, s0_d, s1_d, iomn_d;
    logic        rdn_d, wrn_d, instr_load_d, busy_d, hlda_d;

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_pend_d = err_pend_q;
        wait_cnt_d = wait_cnt;
        rdata_d    = rdata;
        bus_err_d  = bus_err;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold) begin
                    state_d = S_THOLD;
                end else if (start) begin
                    state_d    = S_T1;
                    type_d     = (cycle_type == CT_RSVD) ? CT_MEM_RD : cycle_type;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    wait_cnt_d = 8'd0;
                    bus_err_d  = 1'b0;
                    err_pend_d = 1'b0;
                end
            end
            S_T1: begin
                state_d = (type_q == CT_HALT) ? S_THALT : S_T2;
            end
            S_T2, S_TWAIT: begin
                if (ready) begin
                    state_d = S_T3;
                end else if (wait_cnt >= WAIT_LIMIT) begin
                    state_d    = S_T3;
                    err_pend_d = 1'b1;
                end else begin
                    state_d    = S_TWAIT;
                    wait_cnt_d = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
                end
            end
            S_T3: begin
                if (is_read(type_q)) begin
                    rdata_d = ad_in;
                end
                if (type_q == CT_FETCH) begin
                    state_d = S_T4;
                end else begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    bus_err_d = err_pend_q;
                end
            end
            S_T4: begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                bus_err_d = err_pend_q;
            end
            S_THOLD: begin
                if (!hold) begin
                    state_d = S_IDLE;
                end
            end
            S_THALT: begin
                if (wake) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Moore outputs for the state being entered, so the registered
        // outputs line up exactly with the T-state they describe.
        haddress_d   = 8'd0;
        ad_out_d     = 8'd0;
        ad_oe_d      = 1'b0;
        ale_d        = 1'b0;
        {s1_d, s0_d, iomn_d} = 3'b000;
        rdn_d        = 1'b1;
        wrn_d        = 1'b1;
        instr_load_d = 1'b0;
        busy_d       = 1'b0;
        hlda_d       = 1'b0;

        case (state_d)
            S_T1: begin
                ale_d      = 1'b1;
                ad_out_d   = addr_d[7:0];
                ad_oe_d    = 1'b1;
                haddress_d = addr_d[15:8];
                {s1_d, s0_d, iomn_d} = status_bits(type_d);
                busy_d     = 1'b1;
            end
            S_T2, S_TWAIT, S_T3: begin
                haddress_d = addr_d[15:8];
                {s1_d, s0_d, iomn_d} = status_bits(type_d);
                busy_d     = 1'b1;
                if (is_write(type_d)) begin
                    wrn_d    = 1'b0;
                    ad_out_d = wdata_d;
                    ad_oe_d  = 1'b1;
                end else begin
                    rdn_d = 1'b0;
                end
            end
            S_T4: begin
                haddress_d   = addr_d[15:8];
                {s1_d, s0_d, iomn_d} = status_bits(type_d);
                busy_d       = 1'b1;
                instr_load_d = 1'b1;
            end
            S_THALT: begin
                haddress_d = addr_d[15:8];
                {s1_d, s0_d, iomn_d} = status_bits(type_d);
                busy_d     = 1'b1;
            end
            S_THOLD: begin
                hlda_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge phi1) begin
        if (!resetn_in) begin
            state_q    <= S_IDLE;
            type_q     <= 3'd0;
            addr_q     <= 16'd0;
            wdata_q    <= 8'd0;
            err_pend_q <= 1'b0;
            haddress   <= 8'd0;
            ad_out     <= 8'd0;
            ad_oe      <= 1'b0;
            ALE        <= 1'b0;
            S0         <= 1'b0;
            S1         <= 1'b0;
            IOMn       <= 1'b0;
            RDn        <= 1'b1;
            WRn        <= 1'b1;
            rdata      <= 8'd0;
            instr_load <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bus_err    <= 1'b0;
            hlda       <= 1'b0;
            wait_cnt   <= 8'd0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_pend_q <= err_pend_d;
            haddress   <= haddress_d;
            ad_out     <= ad_out_d;
            ad_oe      <= ad_oe_d;
            ALE        <= ale_d;
            S0         <= s0_d;
            S1         <= s1_d;
            IOMn       <= iomn_d;
            RDn        <= rdn_d;
            WRn        <= wrn_d;
            rdata      <= rdata_d;
            instr_load <= instr_load_d;
            busy       <= busy_d;
            done       <= done_d;
            bus_err    <= bus_err_d;
            hlda       <= hlda_d;
            wait_cnt   <= wait_cnt_d;
        end
    end

endmodule
